keypad_key_emulator: RTL
========================

Name: keypad_key_emulator

Overview:
- Synthesizable responder for the 3x3 keypad scan interface; emulates the physical keypad at the far end of the scanner.
- Accepts key codes 1-9 over a valid/ready handshake and drives the column lines from the scanner's row drives, as a real key closure would.
- Each press runs for a programmed hold time, with optional contact bounce, then a release gap.
- Used for on-board self-test and for closed-loop verification of the digit-entry and lock-controller path.

Parameters:
- HOLD_CYCLES, 240000: cycles the key stays solidly closed after bounce ends (20 ms at 12 MHz); must be >=1.
- GAP_CYCLES, 240000: cycles of guaranteed release after a press before the next code is accepted; must be >=1.
- BOUNCE_CYCLES, 0: length of the bounce window at press start; 0 disables bounce.
- BOUNCE_PERIOD, 1200: contact toggles every BOUNCE_PERIOD cycles inside the bounce window; must be >=1.
- ACTIVE_LOW, 1: 1 means rows are driven low to select and a closed key pulls its column low; 0 means active-high.

Ports:
- hwclk  input  1  system clock, 12 MHz.
- reset  input  1  synchronous, active-high reset.
- keypad_r1, keypad_r2, keypad_r3  input  1 each  row drives from the scanner.
- keypad_c1, keypad_c2, keypad_c3  output  1 each  column lines back to the scanner.
- key_in  input  4  key code to press; valid values are 1-9.
- key_valid  input  1  key_in is presented.
- key_ready  output  1  block can accept a code.
- busy  output  1  a press or gap is in progress.
- done  output  1  one-cycle pulse at the end of the gap.
- err  output  1  one-cycle pulse when an invalid code is accepted.

Behaviour:
- Key mapping: code k in 1..9 gives row = (k-1)/3 and col = (k-1)%3. Codes 1,2,3 are on r1; 4,5,6 on r2; 7,8,9 on r3. Column index 0,1,2 corresponds to c1,c2,c3.
- Column outputs are combinational from the rows. contact_closed is a registered bit. Column c asserts when contact_closed=1, c equals the latched column, and the latched row input is asserted. All non-asserted columns are held at the idle level (1 if ACTIVE_LOW, else 0). There is no register delay from a row change to the column.
- State machine: IDLE, BOUNCE, HOLD, GAP. A single down-counter of at least 32 bits is shared across the timed states.
- IDLE: key_ready=1, busy=0, contact_closed=0.
  - On key_valid & key_ready with a valid code: latch row/col and go to BOUNCE, or straight to HOLD if BOUNCE_CYCLES=0. contact_closed=1 from the next cycle.
  - On a handshake with code 0 or 10-15: pulse err the next cycle and stay in IDLE. No press and no done.
- BOUNCE: contact_closed starts at 1 and inverts each time BOUNCE_PERIOD cycles elapse. After exactly BOUNCE_CYCLES cycles go to HOLD with contact_closed=1.
- HOLD: contact_closed=1 for exactly HOLD_CYCLES cycles, then go to GAP with contact_closed=0.
- GAP: contact_closed=0 for exactly GAP_CYCLES cycles. Then go to IDLE and pulse done=1 on the cycle key_ready returns high.
- key_ready=0 and busy=1 in BOUNCE, HOLD and GAP. key_valid is ignored while key_ready=0, and the block never queues codes.
- Latency: columns reflect the new key on the first cycle after the handshake; total press-to-ready time is BOUNCE_CYCLES+HOLD_CYCLES+GAP_CYCLES cycles.
- Multiple asserted rows: only the latched row matters. If the latched row is asserted, the column asserts regardless of the other rows.
- Reset, including mid-press: on the next edge go to IDLE with contact_closed=0 and the counter cleared. done=0, err=0, key_ready=1. Columns are idle in the same cycle reset is sampled.
- Reset values: key_ready=1, busy=0, done=0, err=0, all columns at the idle level.
- key_valid asserted together with reset is ignored.

Test Plan:
- Press code 5 with ACTIVE_LOW=1, HOLD=10, GAP=5, BOUNCE=0, scanner rows cycling one-low. Required: c2 is low only while r2 is low, for exactly 10 cycles; key_ready rises and done pulses 15 cycles after the handshake.
- Press codes 1, 9 and 7 back-to-back with key_valid held high. Required: each code is accepted only when key_ready=1 and the columns map to c1, c3 and c1 respectively; exactly 3 done pulses.
- Present code 0, then code 12. Required: err pulses one cycle each; key_ready never drops and the columns stay at 1.
- Press code 3 with BOUNCE_CYCLES=8, BOUNCE_PERIOD=2 and r1 held low. Required: c3 follows the pattern 0,0,1,1,0,0,1,1 and then stays 0 for HOLD_CYCLES.
- Press code 6 and assert reset at HOLD cycle 4. Required: c3 returns to 1 the same cycle; after reset key_ready=1, busy=0 and no done pulse.
- Press code 8 with ACTIVE_LOW=0 and r3 held high. Required: c2=1 during HOLD and 0 otherwise.

Source files
------------

// File: rtl/keypad_key_emulator.sv
// Far-end emulation of a 3x3 keypad: presses one accepted key code (1-9) as a
// closure between the latched row and column, with optional bounce, a hold time and a release gap.
module keypad_key_emulator #(
  parameter int unsigned HOLD_CYCLES   = 240000,
  parameter int unsigned GAP_CYCLES    = 240000,
  parameter int unsigned BOUNCE_CYCLES = 0,
  parameter int unsigned BOUNCE_PERIOD = 1200,
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic       keypad_r1,
  input  logic       keypad_r2,
  input  logic       keypad_r3,
  output logic       keypad_c1,
  output logic       keypad_c2,
  output logic       keypad_c3,
  input  logic [3:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] state_dbg
);

  // Handshake: a code is taken on a rising hwclk edge where key_valid and key_ready
  // are both high; key_ready is high only in IDLE, and nothing is queued while busy.
  typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_HOLD, S_GAP} state_t;

  localparam logic [31:0] BOUNCE_LOAD = 32'(BOUNCE_CYCLES - 1);
  localparam logic [31:0] PERIOD_LOAD = 32'(BOUNCE_PERIOD - 1);
  localparam logic [31:0] HOLD_LOAD   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] GAP_LOAD    = 32'(GAP_CYCLES - 1);

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] per_cnt;
  logic [1:0]  row_q;
  logic [1:0]  col_q;
  logic        contact_closed;

  logic        dec_ok;
  logic [1:0]  dec_row;
  logic [1:0]  dec_col;

  always_comb begin
    dec_ok  = 1'b1;
    dec_row = 2'd0;
    dec_col = 2'd0;
    case (key_in)
      4'd1: begin dec_row = 2'd0; dec_col = 2'd0; end
      4'd2: begin dec_row = 2'd0; dec_col = 2'd1; end
      4'd3: begin dec_row = 2'd0; dec_col = 2'd2; end
      4'd4: begin dec_row = 2'd1; dec_col = 2'd0; end
      4'd5: begin dec_row = 2'd1; dec_col = 2'd1; end
      4'd6: begin dec_row = 2'd1; dec_col = 2'd2; end
      4'd7: begin dec_row = 2'd2; dec_col = 2'd0; end
      4'd8: begin dec_row = 2'd2; dec_col = 2'd1; end
      4'd9: begin dec_row = 2'd2; dec_col = 2'd2; end
      default: dec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      per_cnt        <= '0;
      row_q          <= 2'd0;
      col_q          <= 2'd0;
      contact_closed <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (key_valid) begin
            if (dec_ok) begin
              row_q          <= dec_row;
              col_q          <= dec_col;
              contact_closed <= 1'b1;
              if (BOUNCE_CYCLES != 0) begin
                state   <= S_BOUNCE;
                cnt     <= BOUNCE_LOAD;
                per_cnt <= PERIOD_LOAD;
              end else begin
                state <= S_HOLD;
                cnt   <= HOLD_LOAD;
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_BOUNCE: begin
          if (cnt == '0) begin
            state          <= S_HOLD;
            cnt            <= HOLD_LOAD;
            contact_closed <= 1'b1;
          end else begin
            cnt <= cnt - 32'd1;
            // The contact flips once per elapsed bounce period.
            if (per_cnt == '0) begin
              contact_closed <= ~contact_closed;
              per_cnt        <= PERIOD_LOAD;
            end else begin
              per_cnt <= per_cnt - 32'd1;
            end
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            state          <= S_GAP;
            cnt            <= GAP_LOAD;
            contact_closed <= 1'b0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign key_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Columns follow the rows combinationally; reset forces them idle in the same cycle.
  logic [2:0] rows_act;
  logic [2:0] cols_act;
  logic       row_hit;

  assign rows_act = (ACTIVE_LOW != 0) ? ~{keypad_r3, keypad_r2, keypad_r1}
                                      :  {keypad_r3, keypad_r2, keypad_r1};
  assign row_hit  = rows_act[row_q];
  assign cols_act = {3{contact_closed & row_hit & ~reset}} & (3'b001 << col_q);

  assign {keypad_c3, keypad_c2, keypad_c1} = (ACTIVE_LOW != 0) ? ~cols_act : cols_act;

endmodule
